chip8_fb_draw_ctrl: RTL and testbench

CHIP8_FB_DRAW_CTRL -- requirements
Module: chip8_fb_draw_ctrl

---
 rtl/chip8_fb_draw_ctrl_if.sv | 30 +++
 rtl/chip8_fb_draw_ctrl.sv | 126 ++++++++++++
 tb/tb_chip8_fb_draw_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_fb_draw_ctrl_if.sv
// chip8_fb_draw_ctrl_if: command, sprite-memory and framebuffer bus of the CHIP-8 draw controller.
interface chip8_fb_draw_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [3:0]  cmd_n;
    logic [11:0] cmd_addr;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [4:0]  fb_addr_y;
    logic [5:0]  fb_addr_x;
    logic        fb_writedata;
    logic        fb_WE;
    logic        fb_readdata;
    logic        done;
    logic        collision;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_addr, mem_rdata, fb_readdata,
        input  cmd_ready, mem_req, mem_addr, fb_addr_y, fb_addr_x, fb_writedata, fb_WE, done, collision
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_addr, mem_rdata, fb_readdata,
        output cmd_ready, mem_req, mem_addr, fb_addr_y, fb_addr_x, fb_writedata, fb_WE, done, collision
    );
endinterface

// File: rtl/chip8_fb_draw_ctrl.sv
// chip8_fb_draw_ctrl: CHIP-8 CLS/DXYN framebuffer draw controller with XOR sprite drawing and VF collision.
// Define FB_DRAW_WRAP_EN to wrap off-screen sprite pixels around the 64x32 screen instead of clipping them.
module chip8_fb_draw_ctrl #(
    parameter int FB_RD_LAT  = 2,
    parameter int MEM_RD_LAT = 1
) (
    input logic             clk,
    input logic             reset,
    chip8_fb_draw_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLR     = 3'd1;
    localparam logic [2:0] FETCH   = 3'd2;
    localparam logic [2:0] SCAN    = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] WR      = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
    localparam logic [7:0] MLAT    = 8'(MEM_RD_LAT);
    localparam logic [7:0] FLAT    = 8'(FB_RD_LAT);

    logic [2:0]  state, adv;
    logic [5:0]  x0, cx;
    logic [4:0]  y0, cy;
    logic [3:0]  n, r;
    logic [2:0]  i;
    logic [11:0] base;
    logic [7:0]  spr, wcnt;
    logic        old, coll, clip;

`ifdef FB_DRAW_WRAP_EN
    logic [5:0] col;
    logic [4:0] row;
    assign col  = x0 + {3'd0, i};
    assign row  = y0 + {1'b0, r};
    assign clip = 1'b0;
`else
    logic [6:0] col;
    logic [5:0] row;
    assign col  = {1'b0, x0} + {4'd0, i};
    assign row  = {1'b0, y0} + {2'd0, r};
    assign clip = col[6] | row[5];
`endif

    assign bus.cmd_ready    = state == IDLE;
    assign bus.mem_req      = state == FETCH && wcnt == 8'd0;
    assign bus.mem_addr     = base + {8'd0, r};
    assign bus.fb_WE        = state == CLR || state == WR;
    assign bus.fb_writedata = state == WR && !old;
    assign bus.fb_addr_x    = state == CLR ? cx : col[5:0];
    assign bus.fb_addr_y    = state == CLR ? cy : row[4:0];
    assign bus.done         = state == DONE;
    assign bus.collision    = coll;

    // Where a finished pixel slot leads: next bit, next row's fetch, or completion.
    always_comb adv = (i == 3'd7) ? ((r == n - 4'd1) ? DONE : FETCH) : SCAN;

    // Command sequencing: clear sweep, per-row sprite fetch, and read-modify-write of set pixels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            x0    <= '0;
            y0    <= '0;
            cx    <= '0;
            cy    <= '0;
            n     <= '0;
            r     <= '0;
            i     <= '0;
            base  <= '0;
            spr   <= '0;
            wcnt  <= '0;
            old   <= 1'b0;
            coll  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    coll  <= 1'b0;
                    cx    <= '0;
                    cy    <= '0;
                    r     <= '0;
                    i     <= '0;
                    wcnt  <= '0;
                    x0    <= bus.cmd_x[5:0];
                    y0    <= bus.cmd_y[4:0];
                    n     <= bus.cmd_n;
                    base  <= bus.cmd_addr;
                    state <= !bus.cmd_op ? CLR : (bus.cmd_n == 4'd0 ? DONE : FETCH);
                end
                CLR: begin
                    cx <= cx + 6'd1;
                    if (cx == 6'd63) cy <= cy + 5'd1;
                    if (cx == 6'd63 && cy == 5'd31) state <= DONE;
                end
                FETCH: begin
                    wcnt <= wcnt == MLAT ? 8'd0 : wcnt + 8'd1;
                    if (wcnt == MLAT) begin
                        spr   <= bus.mem_rdata;
                        state <= SCAN;
                    end
                end
                SCAN: if (spr[~i] && !clip) begin
                    wcnt  <= 8'd1;
                    state <= RD_WAIT;
                end else begin
                    i     <= i + 3'd1;
                    if (i == 3'd7) r <= r + 4'd1;
                    state <= adv;
                end
                RD_WAIT: begin
                    wcnt <= wcnt >= FLAT ? 8'd0 : wcnt + 8'd1;
                    if (wcnt >= FLAT) begin
                        old   <= bus.fb_readdata;
                        coll  <= coll | bus.fb_readdata;
                        state <= WR;
                    end
                end
                WR: begin
                    i     <= i + 3'd1;
                    if (i == 3'd7) r <= r + 4'd1;
                    state <= adv;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chip8_fb_draw_ctrl.sv
// tb_chip8_fb_draw_ctrl: directed and randomized checks of the draw controller against a pixel-level model.
module tb_chip8_fb_draw_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    chip8_fb_draw_ctrl_if bus();
    chip8_fb_draw_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0]  mem [4096];
    logic        tb_fb [32][64];
    bit          ref_fb [32][64];
    logic [10:0] p0, p1;
    logic [11:0] got[$];
    logic [11:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;

    // Memory and framebuffer models with their read latencies; every write is logged.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_req ? mem[bus.mem_addr] : 8'($urandom);
        p0 <= {bus.fb_addr_y, bus.fb_addr_x};
        p1 <= p0;
        if (bus.fb_WE) begin
            tb_fb[bus.fb_addr_y][bus.fb_addr_x] <= bus.fb_writedata;
            got.push_back({bus.fb_addr_y, bus.fb_addr_x, bus.fb_writedata});
        end
        if (bus.done) done_count <= done_count + 1;
    end
    assign bus.fb_readdata = tb_fb[p1[10:6]][p1[5:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_cls();
        exp_q.delete();
        for (int w = 0; w < 32; w++)
            for (int c = 0; c < 64; c++) begin
                ref_fb[w][c] = 1'b0;
                exp_q.push_back({5'(w), 6'(c), 1'b0});
            end
    endtask

    task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                              input logic [11:0] a, output bit coll);
        logic [7:0] b;
        int c, w;
        bit o;
        coll = 1'b0;
        exp_q.delete();
        for (int r = 0; r < int'(n); r++) begin
            b = mem[(int'(a) + r) % 4096];
            for (int k = 0; k < 8; k++) begin
                if (b[7 - k]) begin
                    c = int'(x) % 64 + k;
                    w = int'(y) % 32 + r;
`ifdef FB_DRAW_WRAP_EN
                    c = c % 64;
                    w = w % 32;
`endif
                    if (c < 64 && w < 32) begin
                        o = ref_fb[w][c];
                        coll |= o;
                        ref_fb[w][c] = ~o;
                        exp_q.push_back({5'(w), 6'(c), ~o});
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic op, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] a);
        int start;
        @(negedge clk);
        check("idle_ready", 32'(bus.cmd_ready), 1);
        got.delete();
        start = done_count;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_n     = n;
        bus.cmd_addr  = a;
        @(negedge clk);
        check("busy_ready", 32'(bus.cmd_ready), 0);
        if (!op) check("cls_first", 32'({bus.fb_WE, bus.fb_addr_y, bus.fb_addr_x}), 32'h800);
        bus.cmd_op   = ~op;
        bus.cmd_x    = 8'($urandom);
        bus.cmd_y    = 8'($urandom);
        bus.cmd_n    = 4'($urandom);
        bus.cmd_addr = 12'($urandom);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 5000 && done_count == start; k++) @(negedge clk);
        check("done_pulse", 32'(done_count), 32'(start + 1));
        check("done_low", 32'(bus.done), 0);
    endtask

    task automatic cmp(input string tag, input bit coll);
        int bad;
        check({tag, "_writes"}, 32'(got.size()), 32'(exp_q.size()));
        bad = 0;
        for (int k = 0; k < got.size() && k < exp_q.size(); k++)
            if (got[k] !== exp_q[k]) bad++;
        check({tag, "_seq"}, 32'(bad), 0);
        check({tag, "_coll"}, 32'(bus.collision), 32'(coll));
        bad = 0;
        for (int w = 0; w < 32; w++)
            for (int c = 0; c < 64; c++)
                if (tb_fb[w][c] !== ref_fb[w][c]) bad++;
        check({tag, "_fb"}, 32'(bad), 0);
    endtask

    initial begin
        logic [7:0]  rx, ry;
        logic [3:0]  rn;
        logic [11:0] ra;
        bit coll;
        int ds;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_n     = '0;
        bus.cmd_addr  = '0;
        for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        check("rst_we", 32'(bus.fb_WE), 0);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_coll", 32'(bus.collision), 0);
        check("rst_wd", 32'(bus.fb_writedata), 0);
        check("rst_fb_addr", 32'({bus.fb_addr_y, bus.fb_addr_x}), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        reset = 1'b1;

        model_cls();
        issue(1'b0, 8'd0, 8'd0, 4'd0, 12'd0);
        cmp("cls", 1'b0);
        check("cls_last", 32'(got[$]), 32'hFFE);

        mem[12'h200] = 8'h80;
        model_draw(8'd1, 8'd1, 4'd1, 12'h200, coll);
        issue(1'b1, 8'd1, 8'd1, 4'd1, 12'h200);
        cmp("draw_set", coll);
        check("draw_set_pix", 32'(got[0]), 32'h083);
        check("draw_set_coll", 32'(bus.collision), 0);

        model_draw(8'd1, 8'd1, 4'd1, 12'h200, coll);
        issue(1'b1, 8'd1, 8'd1, 4'd1, 12'h200);
        cmp("draw_erase", coll);
        check("draw_erase_pix", 32'(got[0]), 32'h082);
        check("draw_erase_coll", 32'(bus.collision), 1);

        model_draw(8'd65, 8'd33, 4'd1, 12'h200, coll);
        issue(1'b1, 8'd65, 8'd33, 4'd1, 12'h200);
        cmp("draw_mod", coll);
        check("draw_mod_pix", 32'(got[0]), 32'h083);

        mem[12'h300] = 8'hFF;
        mem[12'h301] = 8'hFF;
        model_draw(8'd60, 8'd31, 4'd2, 12'h300, coll);
        issue(1'b1, 8'd60, 8'd31, 4'd2, 12'h300);
        cmp("edge", coll);
`ifdef FB_DRAW_WRAP_EN
        check("edge_count", 32'(got.size()), 16);
`else
        check("edge_count", 32'(got.size()), 4);
`endif

        model_draw(8'd5, 8'd5, 4'd0, 12'h200, coll);
        issue(1'b1, 8'd5, 8'd5, 4'd0, 12'h200);
        cmp("n_zero", coll);

        for (int t = 0; t < 30; t++) begin
            if (t % 10 == 9) begin
                model_cls();
                issue(1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom));
                cmp("rand_cls", 1'b0);
            end else begin
                rx = 8'($urandom);
                ry = 8'($urandom);
                rn = 4'($urandom_range(0, 15));
                ra = (t % 4 == 0) ? 12'hFF8 + 12'($urandom_range(0, 7)) : 12'($urandom);
                for (int k = 0; k < 16; k++) mem[(int'(ra) + k) % 4096] = 8'($urandom);
                model_draw(rx, ry, rn, ra, coll);
                issue(1'b1, rx, ry, rn, ra);
                cmp("rand_draw", coll);
            end
        end

        @(negedge clk);
        got.delete();
        ds = done_count;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 500 && got.size() < 99; k++) @(negedge clk);
        check("abort_we_high", 32'(bus.fb_WE), 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_we_low", 32'(bus.fb_WE), 0);
        check("abort_ready", 32'(bus.cmd_ready), 1);
        check("abort_writes", 32'(got.size()), 100);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(ds));
        check("abort_writes_after", 32'(got.size()), 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
